// File: rtl/online_mult_ctrl_hd_param.sv
// Control FSM for the digit-serial online multiplier: operand handshakes, CA_RAM address sequencing, result handshake.
// Optional stall counter output stall_cnt enabled by defining ONLINE_MULT_PERF_CNT_EN.
module online_mult_ctrl_hd_param #(
  parameter int RAM_ADDR_WIDTH = 7,
  parameter int DIGIT_WIDTH    = 2,
  parameter int NUM_DIGITS     = 64
) (
  input  logic                      clk,
  input  logic                      asyn_reset,
  input  logic [DIGIT_WIDTH-1:0]    x_value,
  input  logic [DIGIT_WIDTH-1:0]    y_value,
  input  logic                      data_x_vld,
  output logic                      data_x_rdy,
  input  logic                      data_y_vld,
  output logic                      data_y_rdy,
  output logic                      data_out_vld,
  input  logic                      data_out_rdy,
  output logic                      data_out_last,
  output logic [DIGIT_WIDTH-1:0]    x_value_reg,
  output logic [DIGIT_WIDTH-1:0]    y_value_reg,
  output logic [RAM_ADDR_WIDTH-1:0] computation_cycle,
  output logic                      write_enable,
  output logic                      enable_all,
  output logic [2:0]                STATE,
  output logic [RAM_ADDR_WIDTH-1:0] digit_idx,
`ifdef ONLINE_MULT_PERF_CNT_EN
  output logic [15:0]               stall_cnt,
`endif
  output logic                      busy
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > (2 ** RAM_ADDR_WIDTH)) begin : g_bad_num_digits
    $error("NUM_DIGITS out of range for RAM_ADDR_WIDTH");
  end

  typedef enum logic [2:0] {
    S_START    = 3'd0,
    S_WRITE_IN = 3'd1,
    S_READ_OUT = 3'd2,
    S_RO_LAST  = 3'd3,
    S_END      = 3'd4
  } state_t;

  localparam logic [RAM_ADDR_WIDTH-1:0] ONE      = RAM_ADDR_WIDTH'(1);
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_IDX = RAM_ADDR_WIDTH'(NUM_DIGITS - 1);

  state_t                    state_q, state_d;
  logic                      hd_x_q, hd_x_d, hd_y_q, hd_y_d;
  logic [RAM_ADDR_WIDTH-1:0] cc_q, cc_d;
  logic [RAM_ADDR_WIDTH-1:0] didx_q, didx_d;
  logic [DIGIT_WIDTH-1:0]    xr_q, xr_d, yr_q, yr_d;
  logic                      x_fire, y_fire, go;

  assign x_fire = (state_q == S_START) && !hd_x_q && data_x_vld;
  assign y_fire = (state_q == S_START) && !hd_y_q && data_y_vld;
  assign go     = (hd_x_q || x_fire) && (hd_y_q || y_fire);

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      state_q <= S_START;
      hd_x_q  <= 1'b0;
      hd_y_q  <= 1'b0;
      cc_q    <= '0;
      didx_q  <= '0;
      xr_q    <= '0;
      yr_q    <= '0;
    end else begin
      state_q <= state_d;
      hd_x_q  <= hd_x_d;
      hd_y_q  <= hd_y_d;
      cc_q    <= cc_d;
      didx_q  <= didx_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hd_x_d  = hd_x_q;
    hd_y_d  = hd_y_q;
    cc_d    = cc_q;
    didx_d  = didx_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    case (state_q)
      S_START: begin
        if (x_fire) begin
          xr_d   = x_value;
          hd_x_d = 1'b1;
        end
        if (y_fire) begin
          yr_d   = y_value;
          hd_y_d = 1'b1;
        end
        if (go) begin
          state_d = S_WRITE_IN;
          hd_x_d  = 1'b0;
          hd_y_d  = 1'b0;
          cc_d    = didx_q;
        end
      end
      S_WRITE_IN, S_READ_OUT: begin
        // Address walks down to 0; the 0 address is handled by the last-line state.
        if (cc_q == '0) begin
          state_d = S_RO_LAST;
        end else begin
          cc_d    = cc_q - ONE;
          state_d = S_READ_OUT;
        end
      end
      S_RO_LAST: state_d = S_END;
      S_END: begin
        if (data_out_rdy) begin
          state_d = S_START;
          didx_d  = (didx_q == LAST_IDX) ? '0 : didx_q + ONE;
        end
      end
      default: state_d = S_START;
    endcase
  end

  assign data_x_rdy        = (state_q == S_START) && !hd_x_q;
  assign data_y_rdy        = (state_q == S_START) && !hd_y_q;
  assign data_out_vld      = (state_q == S_END);
  assign data_out_last     = (state_q == S_END) && (didx_q == LAST_IDX);
  assign write_enable      = (state_q == S_WRITE_IN);
  assign enable_all        = (state_q == S_WRITE_IN) || (state_q == S_READ_OUT) || (state_q == S_RO_LAST);
  assign busy              = (state_q != S_START);
  assign STATE             = state_q;
  assign computation_cycle = cc_q;
  assign digit_idx         = didx_q;
  assign x_value_reg       = xr_q;
  assign y_value_reg       = yr_q;

`ifdef ONLINE_MULT_PERF_CNT_EN
  logic [15:0] stall_q;
  logic        stall_inc;

  // One operand held while the other has not arrived, or a result backpressured.
  assign stall_inc = ((state_q == S_END) && !data_out_rdy) ||
                     ((state_q == S_START) && (hd_x_q ^ hd_y_q) && (hd_x_q ? !y_fire : !x_fire));

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_online_mult_ctrl_hd_param.sv
// Self-checking bench for online_mult_ctrl_hd_param (NUM_DIGITS=4): directed tables, corner sequences, random run vs. model.
module tb_online_mult_ctrl_hd_param;
  localparam int AW = 7;
  localparam int DW = 2;
  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          asyn_reset = 1'b1;
  logic [DW-1:0] x_value = '0, y_value = '0;
  logic          data_x_vld = 1'b0, data_y_vld = 1'b0, data_out_rdy = 1'b0;
  logic          data_x_rdy, data_y_rdy, data_out_vld, data_out_last;
  logic [DW-1:0] x_value_reg, y_value_reg;
  logic [AW-1:0] computation_cycle, digit_idx;
  logic          write_enable, enable_all, busy;
  logic [2:0]    STATE;
`ifdef ONLINE_MULT_PERF_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  online_mult_ctrl_hd_param #(.RAM_ADDR_WIDTH(AW), .DIGIT_WIDTH(DW), .NUM_DIGITS(ND)) dut (
    .clk(clk), .asyn_reset(asyn_reset), .x_value(x_value), .y_value(y_value),
    .data_x_vld(data_x_vld), .data_x_rdy(data_x_rdy), .data_y_vld(data_y_vld), .data_y_rdy(data_y_rdy),
    .data_out_vld(data_out_vld), .data_out_rdy(data_out_rdy), .data_out_last(data_out_last),
    .x_value_reg(x_value_reg), .y_value_reg(y_value_reg), .computation_cycle(computation_cycle),
    .write_enable(write_enable), .enable_all(enable_all), .STATE(STATE), .digit_idx(digit_idx),
`ifdef ONLINE_MULT_PERF_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is described by the elapsed cycles since the
  // final operand fire (m_e, 0 = waiting for operands) and its digit index m_k.
  int            m_e, m_k, m_idx, m_stall;
  logic          m_hx, m_hy;
  logic [DW-1:0] m_xr, m_yr;

  function automatic int exp_state();
    if (m_e == 0) return 0;
    if (m_e == 1) return 1;
    if (m_e <= m_k + 1) return 2;
    if (m_e == m_k + 2) return 3;
    return 4;
  endfunction

  function automatic int exp_cc();
    if (m_e == 1) return m_k;
    if (m_e >= 2 && m_e <= m_k + 1) return m_k - (m_e - 1);
    return 0;
  endfunction

  function automatic void model_step(input logic r, input logic xv, input logic yv, input logic ov,
                                     input logic [DW-1:0] xd, input logic [DW-1:0] yd);
    int  st;
    logic xf, yf;
    st = exp_state();
    if (r) begin
      m_e = 0; m_k = 0; m_idx = 0; m_hx = 0; m_hy = 0; m_xr = '0; m_yr = '0; m_stall = 0;
      return;
    end
    if ((st == 4 && !ov) || (st == 0 && (m_hx ^ m_hy) && (m_hx ? !yv : !xv)))
      if (m_stall < 65535) m_stall++;
    if (st == 0) begin
      xf = !m_hx && xv;
      yf = !m_hy && yv;
      if (xf) m_xr = xd;
      if (yf) m_yr = yd;
      if ((m_hx || xf) && (m_hy || yf)) begin
        m_e = 1; m_k = m_idx; m_hx = 0; m_hy = 0;
      end else begin
        m_hx = m_hx || xf; m_hy = m_hy || yf;
      end
    end else if (st == 4) begin
      if (ov) begin
        m_e = 0;
        m_idx = (m_idx == ND - 1) ? 0 : m_idx + 1;
      end
    end else begin
      m_e++;
    end
  endfunction

  task automatic check_all();
    int st;
    st = exp_state();
    chk("STATE", int'(STATE), st);
    chk("computation_cycle", int'(computation_cycle), exp_cc());
    chk("data_x_rdy", int'(data_x_rdy), int'(st == 0 && !m_hx));
    chk("data_y_rdy", int'(data_y_rdy), int'(st == 0 && !m_hy));
    chk("data_out_vld", int'(data_out_vld), int'(st == 4));
    chk("data_out_last", int'(data_out_last), int'(st == 4 && m_idx == ND - 1));
    chk("write_enable", int'(write_enable), int'(st == 1));
    chk("enable_all", int'(enable_all), int'(st >= 1 && st <= 3));
    chk("busy", int'(busy), int'(st != 0));
    chk("digit_idx", int'(digit_idx), m_idx);
    chk("x_value_reg", int'(x_value_reg), int'(m_xr));
    chk("y_value_reg", int'(y_value_reg), int'(m_yr));
`ifdef ONLINE_MULT_PERF_CNT_EN
    chk("stall_cnt", int'(stall_cnt), m_stall);
`endif
  endtask

  task automatic step(input logic r, input logic xv, input logic yv, input logic ov,
                      input logic [DW-1:0] xd, input logic [DW-1:0] yd);
    asyn_reset = r; data_x_vld = xv; data_y_vld = yv; data_out_rdy = ov; x_value = xd; y_value = yd;
    @(posedge clk);
    model_step(r, xv, yv, ov, xd, yd);
    #1;
    check_all();
  endtask

  task automatic run_op();
    int n;
    step(0, 1, 1, 1, 2'd1, 2'd2);
    n = 0;
    while (m_e != 0 && n < 300) begin
      step(0, 0, 0, 1, 2'd0, 2'd0);
      n++;
    end
    chk("op_complete_timeout", n < 300 ? 1 : 0, 1);
  endtask

  typedef struct {
    logic r, xv, yv, ov;
    logic [DW-1:0] xd, yd;
    int st, cc, xrdy, yrdy, vld, last, we, idx, xr, yr;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 1, 0, 2'd1, 2'd3, 1, 0, 0, 0, 0, 0, 1, 0, 1, 3};
    tbl[2] = '{0, 0, 0, 0, 2'd0, 2'd0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 3};
    tbl[3] = '{0, 0, 0, 0, 2'd0, 2'd0, 4, 0, 0, 0, 1, 0, 0, 0, 1, 3};
    tbl[4] = '{0, 0, 0, 1, 2'd0, 2'd0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 3};

`ifdef ONLINE_MULT_PERF_CNT_EN
    step(1, 0, 0, 0, 2'd0, 2'd0);
    step(0, 1, 0, 0, 2'd2, 2'd0);
    step(0, 0, 0, 0, 2'd0, 2'd0);
    step(0, 0, 0, 0, 2'd0, 2'd0);
    step(0, 0, 1, 0, 2'd0, 2'd1);
    step(0, 0, 0, 0, 2'd0, 2'd0);
    step(0, 0, 0, 0, 2'd0, 2'd0);
    repeat (4) step(0, 0, 0, 0, 2'd0, 2'd0);
    chk("stall_cnt_directed", int'(stall_cnt), 6);
    step(0, 0, 0, 1, 2'd0, 2'd0);
`endif

    // Basic operation from reset, literal expectations
    for (int i = 0; i < 5; i++) begin
      step(tbl[i].r, tbl[i].xv, tbl[i].yv, tbl[i].ov, tbl[i].xd, tbl[i].yd);
      chk("tbl_state", int'(STATE), tbl[i].st);
      chk("tbl_cc", int'(computation_cycle), tbl[i].cc);
      chk("tbl_xrdy", int'(data_x_rdy), tbl[i].xrdy);
      chk("tbl_yrdy", int'(data_y_rdy), tbl[i].yrdy);
      chk("tbl_vld", int'(data_out_vld), tbl[i].vld);
      chk("tbl_last", int'(data_out_last), tbl[i].last);
      chk("tbl_we", int'(write_enable), tbl[i].we);
      chk("tbl_idx", int'(digit_idx), tbl[i].idx);
      chk("tbl_xr", int'(x_value_reg), tbl[i].xr);
      chk("tbl_yr", int'(y_value_reg), tbl[i].yr);
    end

    // Reset in READ_OUT at digit 2
    run_op();
    chk("idx_before_reset", int'(digit_idx), 2);
    step(0, 1, 1, 1, 2'd3, 2'd3);
    chk("wr_cc2", int'(computation_cycle), 2);
    step(0, 0, 0, 1, 2'd0, 2'd0);
    chk("ro_state", int'(STATE), 2);
    step(1, 0, 0, 1, 2'd0, 2'd0);
    chk("rst_state", int'(STATE), 0);
    chk("rst_cc", int'(computation_cycle), 0);
    chk("rst_idx", int'(digit_idx), 0);
    chk("rst_busy", int'(busy), 0);

    // Digit 3 with y lagging x by 2 cycles, then 5-cycle output stall
    repeat (3) run_op();
    step(0, 1, 0, 1, 2'd2, 2'd0);
    step(0, 0, 0, 1, 2'd0, 2'd0);
    step(0, 0, 1, 1, 2'd0, 2'd1);
    chk("lag_wr_state", int'(STATE), 1);
    chk("lag_wr_cc", int'(computation_cycle), 3);
    for (int a = 2; a >= 0; a--) begin
      step(0, 0, 0, 1, 2'd0, 2'd0);
      chk("lag_ro_state", int'(STATE), 2);
      chk("lag_ro_addr", int'(computation_cycle), a);
    end
    step(0, 0, 0, 1, 2'd0, 2'd0);
    chk("lag_rll_state", int'(STATE), 3);
    step(0, 0, 0, 0, 2'd0, 2'd0);
    chk("lag_end_vld", int'(data_out_vld), 1);
    chk("lag_end_last", int'(data_out_last), 1);
    for (int s = 0; s < 5; s++) begin
      step(0, 0, 0, 0, 2'd0, 2'd0);
      chk("stall_vld", int'(data_out_vld), 1);
      chk("stall_state", int'(STATE), 4);
      chk("stall_idx", int'(digit_idx), 3);
    end
    step(0, 0, 0, 1, 2'd0, 2'd0);
    chk("wrap_state", int'(STATE), 0);
    chk("wrap_xrdy", int'(data_x_rdy), 1);
    chk("wrap_yrdy", int'(data_y_rdy), 1);
    chk("wrap_idx", int'(digit_idx), 0);

    // Operand valid while busy is ignored, then accepted in first START cycle
    run_op();
    step(0, 1, 1, 1, 2'd2, 2'd1);
    step(0, 1, 1, 1, 2'd3, 2'd3);
    chk("busy_xrdy", int'(data_x_rdy), 0);
    chk("busy_yrdy", int'(data_y_rdy), 0);
    chk("busy_xr_hold", int'(x_value_reg), 2);
    step(0, 1, 1, 1, 2'd3, 2'd3);
    step(0, 1, 1, 1, 2'd3, 2'd3);
    chk("busy_end_state", int'(STATE), 4);
    step(0, 1, 1, 1, 2'd3, 2'd3);
    chk("busy_start_state", int'(STATE), 0);
    step(0, 1, 1, 1, 2'd3, 2'd3);
    chk("accept_state", int'(STATE), 1);
    chk("accept_xr", int'(x_value_reg), 3);
    chk("accept_yr", int'(y_value_reg), 3);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 9) < 6), DW'($urandom_range(0, 3)), DW'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/online_mult_ctrl_hd_param.md
Name: online_mult_ctrl_hd_param

Overview:
- Parametrised control FSM for the digit-serial online multiplier.
- Accepts one x digit and one y digit per iteration via independent valid/ready handshakes, and drives the CA_RAM write/read-out address sequence and datapath enable.
- Presents each result digit on a valid/ready output handshake.
- Tracks the digit index internally, so no external master counter is needed, and flags the last digit of an NUM_DIGITS-digit operation.

Parameters:
- RAM_ADDR_WIDTH, 7, CA_RAM address width; also the width of computation_cycle and digit_idx.
- DIGIT_WIDTH, 2, width of one signed-digit operand (x_value, y_value).
- NUM_DIGITS, 64, digits per operation; legal range 1 .. 2**RAM_ADDR_WIDTH; out-of-range is an elaboration error.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- asyn_reset  in  1  reset; synchronous, active-high (port name kept for codebase compatibility).
- x_value  in  DIGIT_WIDTH  x operand digit, sampled on x handshake.
- y_value  in  DIGIT_WIDTH  y operand digit, sampled on y handshake.
- data_x_vld  in  1  x digit valid.
- data_x_rdy  out  1  x digit ready.
- data_y_vld  in  1  y digit valid.
- data_y_rdy  out  1  y digit ready.
- data_out_vld  out  1  result digit valid.
- data_out_rdy  in  1  downstream ready.
- data_out_last  out  1  high with data_out_vld when the current digit index is NUM_DIGITS-1.
- x_value_reg  out  DIGIT_WIDTH  captured x digit.
- y_value_reg  out  DIGIT_WIDTH  captured y digit.
- computation_cycle  out  RAM_ADDR_WIDTH  CA_RAM address.
- write_enable  out  1  CA_RAM write strobe.
- enable_all  out  1  datapath enable.
- STATE  out  3  FSM state code.
- digit_idx  out  RAM_ADDR_WIDTH  index of the digit currently being processed.
- busy  out  1  high in any state other than START.

Behaviour:
- Reset (synchronous, dominates all other events, legal mid-operation):
  - STATE=START; hd_x=0, hd_y=0; computation_cycle=0; digit_idx=0; x_value_reg=0, y_value_reg=0.
  - Decoded outputs on the next cycle: data_x_rdy=1, data_y_rdy=1; all other outputs 0.
  - A reset mid-operation abandons the operation and the next digit accepted is index 0.
- Output decoding:
  - All outputs decode from registered state and flags only; there is no combinational path from any input to any output.
- State codes: START=0, WRITE_IN=1, READ_OUT=2, READ_OUT_LAST_LINE=3, END=4; codes 5-7 go to START on the next cycle.
- START:
  - data_x_rdy = !hd_x; data_y_rdy = !hd_y.
  - x fire (vld&rdy): x_value_reg <= x_value, hd_x <= 1. The y side mirrors this. Each digit is captured in its own fire cycle.
  - Condition go = (hd_x | x_fire) & (hd_y | y_fire). When go is true: next state WRITE_IN, hd_x/hd_y cleared, computation_cycle <= digit_idx.
  - If both operands fire in the same cycle, WRITE_IN follows in the next cycle.
- WRITE_IN (exactly 1 cycle):
  - write_enable=1, enable_all=1.
  - If computation_cycle==0, go to READ_OUT_LAST_LINE.
  - Otherwise decrement computation_cycle and go to READ_OUT.
- READ_OUT:
  - enable_all=1.
  - Decrement computation_cycle each cycle until it is 0; then go to READ_OUT_LAST_LINE with computation_cycle held at 0.
- READ_OUT_LAST_LINE (1 cycle): enable_all=1; then go to END.
- END:
  - data_out_vld=1; data_out_last = (digit_idx==NUM_DIGITS-1).
  - On out fire: go directly to START, and update digit_idx <= (digit_idx==NUM_DIGITS-1) ? 0 : digit_idx+1 (wrap).
  - With data_out_rdy low: stay in END and hold vld and all outputs stable.
- Latency: final input fire at cycle T with digit_idx=k gives WRITE_IN at T+1, k READ_OUT cycles, READ_OUT_LAST_LINE at T+k+2, and data_out_vld at T+k+3.
- Inputs outside START: rdy is 0, so vld is ignored; operand values presented early are not lost.
- Arithmetic: unsigned, RAM_ADDR_WIDTH bits; decrements never go below 0.
- NUM_DIGITS=1: digit_idx is always 0; data_out_last=1 on every result.

Optional Feature:
- Macro: ONLINE_MULT_PERF_CNT_EN.
- When defined, adds output stall_cnt [15:0]:
  - Increments each cycle in END with data_out_rdy=0.
  - Increments each cycle in START with exactly one of hd_x/hd_y set and no fire on the other operand.
  - Saturates at 16'hFFFF; cleared by reset.
- When undefined, the port and its logic are absent and all other behaviour is identical.

Test Plan:
- Reset then x and y vld together with values 2'b01/2'b11 (NUM_DIGITS=4) -> both captured; WRITE_IN next cycle with computation_cycle=0 and write_enable=1; READ_OUT_LAST_LINE next; data_out_vld 3 cycles after fire; digit_idx 0->1 on out fire.
- Digit index 3, x fires at T, y fires at T+2 -> WRITE_IN at T+3 with computation_cycle=3; READ_OUT addresses 2,1,0; READ_OUT_LAST_LINE at T+7; data_out_vld at T+8 with data_out_last=1; after out fire digit_idx=0.
- data_out_rdy held low 5 cycles in END -> vld stays 1, STATE=4, and all outputs stay stable; rdy high -> START next cycle with x_rdy=y_rdy=1.
- vld asserted on both operands during READ_OUT -> rdy=0 and no capture; accepted in the first START cycle.
- asyn_reset pulsed during READ_OUT at digit 2 -> next cycle STATE=0, computation_cycle=0, digit_idx=0, busy=0.
- ONLINE_MULT_PERF_CNT_EN, 4-cycle output stall plus 2-cycle y lag -> stall_cnt=6.
